// File: rtl/timer_alarm_ctrl.sv
// Multi-channel alarm scheduler on a free-running time base with a single held interrupt.
// Latency: Time reaching a deadline -> pending after 1 edge -> irq_o after 2 edges.
// Backpressure: irq_o/irq_id_o hold until irq_ack_i; later expiries queue as pending or overrun.
module timer_alarm_ctrl #(
  parameter int NUM_CH = 4,
  parameter int TIME_W = 16,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [TIME_W-1:0] time_i,
  input  logic              wr_en_i,
  input  logic [CH_W-1:0]   wr_ch_i,
  input  logic [TIME_W-1:0] wr_delay_i,
  input  logic              wr_periodic_i,
  input  logic              wr_cancel_i,
  input  logic              irq_ack_i,
  output logic              irq_o,
  output logic [CH_W-1:0]   irq_id_o,
  output logic [NUM_CH-1:0] armed_o,
  output logic [NUM_CH-1:0] overrun_o
);

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     irq_id_q, irq_id_d;
  logic [TIME_W-1:0]   time_prev_q;
  logic [NUM_CH-1:0]   armed_q, armed_d;
  logic [NUM_CH-1:0]   pending_q, pending_d;
  logic [NUM_CH-1:0]   overrun_q, overrun_d;
  logic [NUM_CH-1:0]   periodic_q, periodic_d;
  logic [TIME_W-1:0]   deadline_q [NUM_CH];
  logic [TIME_W-1:0]   deadline_d [NUM_CH];
  logic [TIME_W-1:0]   period_q   [NUM_CH];
  logic [TIME_W-1:0]   period_d   [NUM_CH];

  logic                tick;
  logic                ack_fire;
  logic                cancel_cur;
  logic [TIME_W-1:0]   delay_eff;
  logic [NUM_CH-1:0]   hit_vec, ack_vec, wr_vec;
  logic [CH_W-1:0]     lowest_id;

  // Time only moves on tick cycles; a zero delay is promoted to one tick so it can ever fire.
  assign tick       = (time_i != time_prev_q);
  assign ack_fire   = (state_q == S_BUSY) && irq_ack_i;
  assign cancel_cur = wr_en_i && wr_cancel_i && (wr_ch_i == irq_id_q);
  assign delay_eff  = (wr_delay_i == '0) ? TIME_W'(1) : wr_delay_i;

  // Per-channel event decode: deadline hit, acknowledge target, write target.
  always_comb begin
    hit_vec = '0;
    ack_vec = '0;
    wr_vec  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      hit_vec[c] = tick && armed_q[c] && (time_i == deadline_q[c]);
      ack_vec[c] = ack_fire && (irq_id_q == CH_W'(c));
      wr_vec[c]  = wr_en_i && (wr_ch_i == CH_W'(c));
    end
  end

  // Lowest-index pending channel wins arbitration.
  always_comb begin
    lowest_id = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (pending_q[c]) lowest_id = CH_W'(c);
    end
  end

  // Channel next state: a write or cancel overrides a same-cycle expiry on that channel.
  always_comb begin
    armed_d    = armed_q;
    pending_d  = pending_q;
    overrun_d  = overrun_q;
    periodic_d = periodic_q;
    deadline_d = deadline_q;
    period_d   = period_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_vec[c] && wr_cancel_i) begin
        armed_d[c]   = 1'b0;
        pending_d[c] = 1'b0;
        overrun_d[c] = 1'b0;
      end else if (wr_vec[c]) begin
        deadline_d[c] = time_i + delay_eff;
        period_d[c]   = delay_eff;
        periodic_d[c] = wr_periodic_i;
        armed_d[c]    = 1'b1;
        pending_d[c]  = pending_q[c] && !ack_vec[c];
      end else if (hit_vec[c]) begin
        if (pending_q[c] && !ack_vec[c]) overrun_d[c] = 1'b1;
        pending_d[c] = 1'b1;
        if (periodic_q[c]) deadline_d[c] = deadline_q[c] + period_q[c];
        else               armed_d[c]    = 1'b0;
      end else if (ack_vec[c]) begin
        pending_d[c] = 1'b0;
      end
    end
  end

  // Interrupt FSM: the reported ID is locked while busy; dropping forces a one-cycle gap.
  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    case (state_q)
      S_IDLE: begin
        if (|pending_q) begin
          state_d  = S_BUSY;
          irq_id_d = lowest_id;
        end
      end
      S_BUSY: begin
        if (ack_fire || cancel_cur) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset; time is sampled so no tick follows reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      irq_id_q    <= '0;
      time_prev_q <= time_i;
      armed_q     <= '0;
      pending_q   <= '0;
      overrun_q   <= '0;
      periodic_q  <= '0;
      deadline_q  <= '{default: '0};
      period_q    <= '{default: '0};
    end else begin
      state_q     <= state_d;
      irq_id_q    <= irq_id_d;
      time_prev_q <= time_i;
      armed_q     <= armed_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      periodic_q  <= periodic_d;
      deadline_q  <= deadline_d;
      period_q    <= period_d;
    end
  end

  assign irq_o     = (state_q == S_BUSY);
  assign irq_id_o  = irq_id_q;
  assign armed_o   = armed_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_timer_alarm_ctrl.sv
// Directed scenarios plus random traffic, each cycle compared against a behavioural model.
// Latency: checks sample 1 time unit after every rising clock edge.
// Backpressure: acknowledges are driven directly or randomly; no stalls are modelled.
module tb_timer_alarm_ctrl;
  localparam int NUM_CH = 4;
  localparam int TIME_W = 16;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [TIME_W-1:0] tm;
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [TIME_W-1:0] wr_delay;
  logic              wr_per;
  logic              wr_cancel;
  logic              ack;
  logic              irq;
  logic [CH_W-1:0]   irq_id;
  logic [NUM_CH-1:0] armed;
  logic [NUM_CH-1:0] overrun;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural reference: deadlines kept as plain integers modulo 2^16.
  int m_dl  [NUM_CH];
  int m_per [NUM_CH];
  bit m_periodic [NUM_CH];
  bit m_armed [NUM_CH];
  bit m_pend  [NUM_CH];
  bit m_ovr   [NUM_CH];
  bit m_irq;
  int m_id;
  int m_prev;

  always #5 clk = ~clk;

  timer_alarm_ctrl #(.NUM_CH(NUM_CH), .TIME_W(TIME_W)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .time_i        (tm),
    .wr_en_i       (wr_en),
    .wr_ch_i       (wr_ch),
    .wr_delay_i    (wr_delay),
    .wr_periodic_i (wr_per),
    .wr_cancel_i   (wr_cancel),
    .irq_ack_i     (ack),
    .irq_o         (irq),
    .irq_id_o      (irq_id),
    .armed_o       (armed),
    .overrun_o     (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply the alarm rules to the model for the inputs present before the coming edge.
  task automatic model_edge();
    bit tick, acked, n_irq, hit, ackd;
    int n_id, ack_ch, d;
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_armed[c] = 0; m_pend[c] = 0; m_ovr[c] = 0;
      end
      m_irq = 0; m_id = 0; m_prev = int'(tm);
      return;
    end
    tick   = (int'(tm) != m_prev);
    acked  = m_irq && ack;
    ack_ch = m_id;
    n_id   = m_id;
    if (m_irq) begin
      n_irq = !(acked || (wr_en && wr_cancel && int'(wr_ch) == m_id));
    end else begin
      n_irq = 0;
      for (int c = NUM_CH - 1; c >= 0; c--) begin
        if (m_pend[c]) begin n_irq = 1; n_id = c; end
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      hit  = tick && m_armed[c] && (int'(tm) == m_dl[c]);
      ackd = acked && (ack_ch == c);
      if (wr_en && int'(wr_ch) == c) begin
        if (wr_cancel) begin
          m_armed[c] = 0; m_pend[c] = 0; m_ovr[c] = 0;
        end else begin
          d = (wr_delay == 0) ? 1 : int'(wr_delay);
          m_dl[c] = (int'(tm) + d) % 65536;
          m_per[c] = d;
          m_periodic[c] = wr_per;
          m_armed[c] = 1;
          if (ackd) m_pend[c] = 0;
        end
      end else if (hit) begin
        if (m_pend[c] && !ackd) m_ovr[c] = 1;
        m_pend[c] = 1;
        if (m_periodic[c]) m_dl[c] = (m_dl[c] + m_per[c]) % 65536;
        else m_armed[c] = 0;
      end else if (ackd) begin
        m_pend[c] = 0;
      end
    end
    m_irq = n_irq; m_id = n_id; m_prev = int'(tm);
  endtask

  // One clock: update model, let the edge pass, compare, then drop one-cycle strobes.
  task automatic cyc();
    logic [NUM_CH-1:0] e_armed, e_ovr;
    model_edge();
    @(posedge clk);
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      e_armed[c] = m_armed[c];
      e_ovr[c]   = m_ovr[c];
    end
    chk("model_irq", 32'(irq), 32'(m_irq));
    if (m_irq) chk("model_irq_id", 32'(irq_id), 32'(m_id));
    chk("model_armed", 32'(armed), 32'(e_armed));
    chk("model_overrun", 32'(overrun), 32'(e_ovr));
    wr_en = 0; wr_cancel = 0; ack = 0;
  endtask

  task automatic write(input int ch, input int d, input bit per);
    wr_en = 1; wr_ch = CH_W'(ch); wr_delay = TIME_W'(d); wr_per = per; wr_cancel = 0;
  endtask

  task automatic cancel(input int ch);
    wr_en = 1; wr_ch = CH_W'(ch); wr_cancel = 1;
  endtask

  initial begin
    rst_n = 0; tm = 16'h0010; wr_en = 0; wr_ch = 0; wr_delay = 0;
    wr_per = 0; wr_cancel = 0; ack = 0;
    cyc(); cyc();
    chk("reset_irq", 32'(irq), 0);
    chk("reset_irq_id", 32'(irq_id), 0);
    chk("reset_armed", 32'(armed), 0);
    chk("reset_overrun", 32'(overrun), 0);
    rst_n = 1; cyc();

    // One-shot ch1, D=3 from 0x0010.
    write(1, 3, 0); cyc();
    chk("t1_armed", 32'(armed), 32'h2);
    tm = 16'h0011; cyc();
    tm = 16'h0012; cyc();
    tm = 16'h0013; cyc();
    chk("t1_irq_not_yet", 32'(irq), 0);
    cyc();
    chk("t1_irq", 32'(irq), 1);
    chk("t1_irq_id", 32'(irq_id), 1);
    chk("t1_disarmed", 32'(armed), 0);
    ack = 1; cyc();
    chk("t1_ack_drop", 32'(irq), 0);

    // Periodic ch0, D=2 from 0x0100.
    tm = 16'h0100; write(0, 2, 1); cyc();
    for (int k = 0; k < 3; k++) begin
      tm = tm + 1; cyc();
      tm = tm + 1; cyc();
      cyc();
      chk("t2_irq", 32'(irq), 1);
      chk("t2_irq_id", 32'(irq_id), 0);
      chk("t2_fire_time", 32'(tm), 32'(16'h0102 + 2 * k));
      ack = 1; cyc();
      chk("t2_ack_drop", 32'(irq), 0);
      chk("t2_still_armed", 32'(armed[0]), 1);
    end
    cancel(0); cyc();

    // ch2 and ch3 expire on the same tick.
    tm = 16'h0200; cyc();
    write(2, 2, 0); cyc();
    write(3, 2, 0); cyc();
    tm = 16'h0201; cyc();
    tm = 16'h0202; cyc();
    cyc();
    chk("t3_first_id", 32'(irq_id), 2);
    chk("t3_first_irq", 32'(irq), 1);
    ack = 1; cyc();
    chk("t3_gap", 32'(irq), 0);
    cyc();
    chk("t3_second_irq", 32'(irq), 1);
    chk("t3_second_id", 32'(irq_id), 3);
    ack = 1; cyc();
    cyc();
    chk("t3_quiet", 32'(irq), 0);

    // Overrun on unacknowledged periodic ch0, then cancel.
    tm = 16'h0300; cyc();
    write(0, 1, 1); cyc();
    tm = 16'h0301; cyc();
    tm = 16'h0302; cyc();
    chk("t4_overrun", 32'(overrun), 32'h1);
    chk("t4_irq", 32'(irq), 1);
    cancel(0); cyc();
    chk("t4_overrun_clr", 32'(overrun), 0);
    chk("t4_irq_drop", 32'(irq), 0);
    chk("t4_disarmed", 32'(armed), 0);

    // Wrap-around deadline, then rewrite on the expiry tick.
    tm = 16'hFFFE; cyc();
    write(1, 4, 0); cyc();
    tm = 16'hFFFF; cyc();
    tm = 16'h0000; cyc();
    tm = 16'h0001; cyc();
    tm = 16'h0002; cyc();
    cyc();
    chk("t5_wrap_irq", 32'(irq), 1);
    chk("t5_wrap_id", 32'(irq_id), 1);
    ack = 1; cyc();
    write(1, 2, 0); cyc();
    tm = 16'h0003; cyc();
    tm = 16'h0004; write(1, 5, 0); cyc();
    cyc();
    chk("t5_rewrite_no_irq", 32'(irq), 0);
    chk("t5_rewrite_armed", 32'(armed), 32'h2);
    for (int t = 5; t <= 9; t++) begin
      tm = TIME_W'(t); cyc();
    end
    cyc();
    chk("t5_new_deadline_irq", 32'(irq), 1);

    // Reset while the interrupt is up.
    rst_n = 0; cyc();
    chk("t6_irq", 32'(irq), 0);
    chk("t6_irq_id", 32'(irq_id), 0);
    chk("t6_armed", 32'(armed), 0);
    chk("t6_overrun", 32'(overrun), 0);
    rst_n = 1;
    tm = 16'h000A; cyc();
    tm = 16'h000B; cyc();
    cyc();
    chk("t6_no_spurious", 32'(irq), 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1) == 0) tm = tm + 1;
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 4) == 0) cancel(int'($urandom_range(0, NUM_CH - 1)));
        else write(int'($urandom_range(0, NUM_CH - 1)), int'($urandom_range(0, 6)),
                   bit'($urandom_range(0, 1)));
      end
      ack = ($urandom_range(0, 2) == 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
